// File: rtl/pifo_stfq_rank_calc.sv
// Start-time fair queueing rank calculator for a PIFO scheduler.
// A two-stage pipeline turns (flow, length, weight) into a start tag (rank) and finish tag.
module pifo_stfq_rank_calc #(
   parameter int FLOW_ID_W = 4,
   parameter int LEN_W     = 16,
   parameter int RANK_W    = 32,
   parameter int SHIFT_W   = 3
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [FLOW_ID_W-1:0] in_flow_id,
   input  logic [LEN_W-1:0]     in_pkt_len,
   input  logic [SHIFT_W-1:0]   in_wshift,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [RANK_W-1:0]    out_rank,
   output logic [RANK_W-1:0]    out_finish,
   output logic [FLOW_ID_W-1:0] out_flow_id,
   input  logic                 deq_valid,
   input  logic [RANK_W-1:0]    deq_rank,
   output logic [RANK_W-1:0]    vtime,
   output logic                 init_done
);

   localparam int FLOWS = 1 << FLOW_ID_W;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   function automatic logic [RANK_W-1:0] sat_add(input logic [RANK_W-1:0] a,
                                                 input logic [RANK_W-1:0] b);
      logic [RANK_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[RANK_W] ? {RANK_W{1'b1}} : sum[RANK_W-1:0];
   endfunction

   function automatic logic [RANK_W-1:0] max_rank(input logic [RANK_W-1:0] a,
                                                  input logic [RANK_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   state_t                state_q, state_d;
   logic [FLOW_ID_W-1:0]  clr_ptr_q, clr_ptr_d;
   logic [RANK_W-1:0]     lf_q [FLOWS];
   logic [RANK_W-1:0]     vtime_q, vtime_d;

   logic                  s1_valid_q;
   logic [FLOW_ID_W-1:0]  s1_flow_q;
   logic [RANK_W-1:0]     s1_cost_q, s1_cost_d;
   logic [RANK_W-1:0]     s1_lf_q, s1_lf_d;
   logic [LEN_W-1:0]      len_shift;

   logic                  out_valid_q;
   logic [RANK_W-1:0]     out_rank_q, out_finish_q;
   logic [FLOW_ID_W-1:0]  out_flow_q;

   logic                  run, advance, accept, s2_load;
   logic [RANK_W-1:0]     start_d, finish_d;

   // FSM: state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_INIT;
         clr_ptr_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
      end
   end

   // FSM: next state, one table entry cleared per INIT cycle
   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == ST_INIT) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == {FLOW_ID_W{1'b1}}) state_d = ST_RUN;
      end
   end

   // FSM: outputs
   always_comb begin
      run       = (state_q == ST_RUN);
      init_done = run;
      in_ready  = run && (!s1_valid_q || advance);
   end

   assign advance   = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign s2_load   = s1_valid_q && advance;
   assign start_d   = max_rank(vtime_q, s1_lf_q);
   assign finish_d  = sat_add(start_d, s1_cost_q);
   assign len_shift = in_pkt_len >> in_wshift;
   assign s1_cost_d = RANK_W'(len_shift);
   // Forward the finish tag being written this cycle so back-to-back packets of one flow chain
   assign s1_lf_d   = (s2_load && (s1_flow_q == in_flow_id)) ? finish_d : lf_q[in_flow_id];

   always_comb begin
      vtime_d = vtime_q;
      if (run && deq_valid) vtime_d = max_rank(vtime_q, deq_rank);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) vtime_q <= '0;
      else       vtime_q <= vtime_d;
   end

   always_ff @(posedge clk) begin
      if (!run)         lf_q[clr_ptr_q] <= '0;
      else if (s2_load) lf_q[s1_flow_q] <= finish_d;
   end

   // Stage 1: capture request and the flow's last finish tag
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        s1_valid_q <= 1'b0;
      else if (accept)  s1_valid_q <= 1'b1;
      else if (advance) s1_valid_q <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_flow_q <= in_flow_id;
         s1_cost_q <= s1_cost_d;
         s1_lf_q   <= s1_lf_d;
      end
   end

   // Stage 2: output register holding start/finish tags
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q  <= 1'b0;
         out_rank_q   <= '0;
         out_finish_q <= '0;
         out_flow_q   <= '0;
      end else if (advance) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_rank_q   <= start_d;
            out_finish_q <= finish_d;
            out_flow_q   <= s1_flow_q;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_rank    = out_rank_q;
   assign out_finish  = out_finish_q;
   assign out_flow_id = out_flow_q;
   assign vtime       = vtime_q;

endmodule

// File: tb/tb_pifo_stfq_rank_calc.sv
// Directed bench for pifo_stfq_rank_calc: vector table streamed through the pipeline
// plus hand-written reset, dequeue, backpressure and saturation sequences.
module tb_pifo_stfq_rank_calc;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_flow_id = '0;
   logic [15:0] in_pkt_len = '0;
   logic [2:0]  in_wshift = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_rank, out_finish;
   logic [3:0]  out_flow_id;
   logic        deq_valid = 1'b0;
   logic [31:0] deq_rank = '0;
   logic [31:0] vtime;
   logic        init_done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pifo_stfq_rank_calc dut (
      .clk(clk), .rstn(rstn),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_flow_id(in_flow_id), .in_pkt_len(in_pkt_len), .in_wshift(in_wshift),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rank(out_rank), .out_finish(out_finish), .out_flow_id(out_flow_id),
      .deq_valid(deq_valid), .deq_rank(deq_rank),
      .vtime(vtime), .init_done(init_done)
   );

   typedef struct {
      logic [3:0]  flow;
      logic [15:0] len;
      logic [2:0]  wshift;
      logic [31:0] exp_rank;
      logic [31:0] exp_finish;
   } vec_t;

   vec_t vec [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i);
      in_valid   = 1'b1;
      in_flow_id = vec[i].flow;
      in_pkt_len = vec[i].len;
      in_wshift  = vec[i].wshift;
   endtask

   // After reset release: in_ready low for 16 edges, then high with init_done
   task automatic check_init();
      bit bad = 0;
      if (in_ready !== 1'b0 || init_done !== 1'b0) bad = 1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i < 16 && (in_ready !== 1'b0 || init_done !== 1'b0)) bad = 1;
      end
      chk("init_hold_low", {63'd0, bad}, 64'd0);
      chk("init_done", {62'd0, init_done, in_ready}, 64'd3);
   endtask

   // Stream vec[first..first+n-1]; out_ready held low for the first 'stall' cycles
   task automatic run(input int first, input int n, input int stall);
      int ri = first;
      int ai = first;
      int cyc = 0;
      bit acc;
      bit have_h = 0;
      logic [31:0] h_rank, h_fin;
      logic [3:0]  h_flow;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = (stall == 0);
      drive(ai);
      while (ri < first + n && cyc < 100) begin
         if (out_valid && out_ready) begin
            chk($sformatf("rank[%0d]", ri), {32'd0, out_rank}, {32'd0, vec[ri].exp_rank});
            chk($sformatf("finish[%0d]", ri), {32'd0, out_finish}, {32'd0, vec[ri].exp_finish});
            chk($sformatf("flow[%0d]", ri), {60'd0, out_flow_id}, {60'd0, vec[ri].flow});
            ri++;
         end else if (out_valid && !out_ready) begin
            if (!have_h) begin
               have_h = 1;
               h_rank = out_rank;
               h_fin  = out_finish;
               h_flow = out_flow_id;
            end else begin
               chk("hold_outputs", {out_rank, out_finish}, {h_rank, h_fin});
               chk("hold_flow", {60'd0, out_flow_id}, {60'd0, h_flow});
               chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            end
         end
         acc = in_valid && in_ready;
         tick();
         cyc++;
         if (acc) ai++;
         if (ai < first + n) drive(ai);
         else in_valid = 1'b0;
         if (cyc >= stall) out_ready = 1'b1;
      end
      in_valid = 1'b0;
      chk($sformatf("stream_done[%0d]", first), ri, first + n);
   endtask

   task automatic deq(input logic [31:0] r, input logic [31:0] exp_vt);
      deq_valid = 1'b1;
      deq_rank  = r;
      tick();
      deq_valid = 1'b0;
      chk("vtime", {32'd0, vtime}, {32'd0, exp_vt});
   endtask

   initial begin
      vec[0]  = '{4'd3,  16'd1000,   3'd0, 32'd0,          32'd1000};
      vec[1]  = '{4'd3,  16'd500,    3'd0, 32'd1000,       32'd1500};
      vec[2]  = '{4'd5,  16'd1024,   3'd2, 32'd0,          32'd256};
      vec[3]  = '{4'd3,  16'd16,     3'd3, 32'd1500,       32'd1502};
      vec[4]  = '{4'd7,  16'hFFFF,   3'd7, 32'd0,          32'd511};
      vec[5]  = '{4'd0,  16'd7,      3'd1, 32'd0,          32'd3};
      vec[6]  = '{4'd3,  16'd8,      3'd3, 32'd1502,       32'd1503};
      vec[7]  = '{4'd5,  16'd1024,   3'd2, 32'd5000,       32'd5256};
      vec[8]  = '{4'd8,  16'd10,     3'd0, 32'd6000,       32'd6010};
      vec[9]  = '{4'd9,  16'd20,     3'd0, 32'd6000,       32'd6020};
      vec[10] = '{4'd10, 16'd30,     3'd0, 32'd6000,       32'd6030};
      vec[11] = '{4'd12, 16'd0,      3'd0, 32'hFFFFFF00,   32'hFFFFFF00};
      vec[12] = '{4'd12, 16'h0200,   3'd0, 32'hFFFFFF00,   32'hFFFFFFFF};
      vec[13] = '{4'd12, 16'd1,      3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF};
      vec[14] = '{4'd3,  16'd10,     3'd0, 32'd0,          32'd10};

      tick();
      tick();
      chk("rst_outputs", {out_rank, out_finish}, 64'd0);
      chk("rst_ctrl", {58'd0, out_valid, in_ready, init_done, out_flow_id == 4'd0, 2'b00}, 64'd4);
      chk("rst_vtime", {32'd0, vtime}, 64'd0);
      rstn = 1'b1;
      check_init();

      run(0, 7, 0);
      deq(32'd5000, 32'd5000);
      run(7, 1, 0);
      deq(32'd100, 32'd5000);

      // Dequeue landing in the same cycle stage 2 loads: old vtime must be used
      tick();
      in_valid = 1'b1; in_flow_id = 4'd6; in_pkt_len = 16'd100; in_wshift = 3'd0;
      tick();
      in_valid = 1'b0;
      deq_valid = 1'b1; deq_rank = 32'd6000;
      tick();
      deq_valid = 1'b0;
      chk("samecyc_valid", {63'd0, out_valid}, 64'd1);
      chk("samecyc_tags", {out_rank, out_finish}, {32'd5000, 32'd5100});
      chk("samecyc_vtime", {32'd0, vtime}, 64'd6000);

      run(8, 3, 6);
      deq(32'hFFFFFF00, 32'hFFFFFF00);
      run(11, 3, 0);

      // Mid-stream reset discards in-flight work and re-clears the table
      tick();
      drive(14);
      tick();
      tick();
      rstn = 1'b0;
      #2;
      chk("mid_rst_ctrl", {60'd0, out_valid, in_ready, init_done, 1'b0}, 64'd0);
      chk("mid_rst_vtime", {32'd0, vtime}, 64'd0);
      chk("mid_rst_tags", {out_rank, out_finish}, 64'd0);
      in_valid = 1'b0;
      tick();
      rstn = 1'b1;
      check_init();
      run(14, 1, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

// File: doc/pifo_stfq_rank_calc.md
PIFO_STFQ_RANK_CALC -- requirements
Module: pifo_stfq_rank_calc

Interface
REQ-001 Parameter FLOW_ID_W, default 4, flow-ID width; the flow table holds FLOWS = 2^FLOW_ID_W entries.
REQ-002 Parameter LEN_W, default 16, packet-length width.
REQ-003 Parameter RANK_W, default 32, rank, finish-tag and virtual-time width.
REQ-004 Parameter SHIFT_W, default 3, weight-shift width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rstn  in  1  reset; asynchronous, active-low.
REQ-007 in_valid  in  1  enqueue request valid.
REQ-008 in_ready  out  1  block accepts request this cycle.
REQ-009 in_flow_id  in  FLOW_ID_W  flow index.
REQ-010 in_pkt_len  in  LEN_W  packet length, bytes.
REQ-011 in_wshift  in  SHIFT_W  weight as right-shift amount (cost = len >> wshift).
REQ-012 out_valid  out  1  computed rank valid.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out_rank  out  RANK_W  start tag, used as PIFO rank.
REQ-015 out_finish  out  RANK_W  finish tag written back for the flow.
REQ-016 out_flow_id  out  FLOW_ID_W  flow index of result.
REQ-017 deq_valid  in  1  PIFO dequeue event.
REQ-018 deq_rank  in  RANK_W  rank of dequeued element.
REQ-019 vtime  out  RANK_W  current virtual time.
REQ-020 init_done  out  1  flow-table clear complete.

Function
REQ-021 The FSM SHALL have states INIT and RUN; reset enters INIT with clear pointer 0.
REQ-022 INIT SHALL clear one flow-table entry (last_finish = 0) per cycle, in ascending index order; after entry FLOWS-1 it SHALL enter RUN with init_done=1, i.e. FLOWS cycles after reset release.
REQ-023 In INIT, in_ready SHALL be 0 and deq_valid SHALL be ignored.
REQ-024 A transfer occurs when in_valid && in_ready; in_ready = RUN && (!s1_valid || advance), where advance = !out_valid || out_ready.
REQ-025 Stage 1 SHALL register flow_id, cost = in_pkt_len >> in_wshift (zero-extended to RANK_W), and last_finish[flow_id].
REQ-026 If the stage-2 load writes the same flow in the cycle stage 1 loads, stage 1 SHALL capture the value being written (forwarding), not the stale table entry.
REQ-027 Stage 2 (output register) SHALL compute start = max(vtime, last_finish) and finish = start + cost, saturating at 2^RANK_W-1.
REQ-028 Stage 2 SHALL write finish into last_finish[flow] in the same cycle it loads the output register.
REQ-029 Latency: out_valid SHALL assert 2 cycles after acceptance when out_ready is held high; sustained throughput SHALL be 1 result per cycle.
REQ-030 With out_valid=1 and out_ready=0, out_rank, out_finish and out_flow_id SHALL hold, stage 1 SHALL hold, and no table write SHALL occur.
REQ-031 In RUN, on deq_valid, vtime SHALL update to max(vtime, deq_rank); vtime SHALL never decrease.
REQ-032 Stage 2 SHALL use the registered vtime value from before the same-cycle dequeue update.
REQ-033 Results SHALL leave in acceptance order; no request SHALL be dropped or duplicated.

Reset
REQ-034 When rstn=0: out_valid=0, out_rank=0, out_finish=0, out_flow_id=0, vtime=0, init_done=0, in_ready=0, pipeline valid bits 0, FSM=INIT.
REQ-035 When rstn is asserted mid-operation, in-flight requests SHALL be discarded and the flow table SHALL be re-cleared through INIT.

Verification
REQ-036 Reset release, defaults -> in_ready=0 for 16 cycles, then init_done=1 and in_ready=1.
REQ-037 Flow 3, len 1000, wshift 0, vtime 0 -> out_rank 0, out_finish 1000; second flow-3 len 500 back-to-back -> rank 1000, finish 1500 (forwarding).
REQ-038 Flow 5, len 1024, wshift 2 -> finish 256; deq_rank 5000 -> vtime 5000; next flow-5 len 1024 -> rank 5000, finish 5256.
REQ-039 out_ready held 0 for 5 cycles with 3 requests offered -> two results are held in the pipeline, in_ready=0, outputs stable; on release, 3 results arrive in order with no loss.
REQ-040 last_finish 0xFFFFFF00, len 0x200, wshift 0 -> out_finish 0xFFFFFFFF (saturated).
REQ-041 deq_rank 100 after vtime 200 -> vtime stays 200; rstn pulsed low mid-stream -> out_valid=0, vtime=0, INIT repeats.
